// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and the request classifier for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Why a request was rejected; internal, visible for debug only.
    typedef enum logic [1:0] {
        NONE     = 2'd0,
        MISALIGN = 2'd1,
        RANGE    = 2'd2,
        CONFLICT = 2'd3
    } dmem_cause_t;

    function automatic dmem_cause_t classify(
        input logic              rd,
        input logic              wr,
        input logic [WORD_W-1:0] addr,
        input logic [WORD_W-1:0] depth
    );
        if (rd && wr)
            return CONFLICT;
        if (addr[1:0] != 2'b00)
            return MISALIGN;
        if ({2'b00, addr[WORD_W-1:2]} >= depth)
            return RANGE;
        return NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Memory-stage request/response bundle between core and dmem.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              MemRead;
    logic              MemWrite;
    logic [WORD_W-1:0] Addr;
    logic [WORD_W-1:0] WriteData;
    logic [WORD_W-1:0] ReadData;
    logic              Ready;
    logic              Stall;
    logic              Error;

    modport slave (
        input  MemRead, MemWrite, Addr, WriteData,
        output ReadData, Ready, Stall, Error
    );

    modport master (
        output MemRead, MemWrite, Addr, WriteData,
        input  ReadData, Ready, Stall, Error
    );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Single-port synchronous word RAM with registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             we,
    input  wire logic             re,
    input  wire logic             clr,
    input  wire logic [AW-1:0]    waddr,
    input  wire logic [WIDTH-1:0] wdata,
    output logic      [WIDTH-1:0] rdata
);

    // Storage deliberately has no reset so contents survive rst.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we)
            r_mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rdata <= '0;
        else if (clr)
            r_rdata <= '0;
        else if (re)
            r_rdata <= r_mem[waddr];
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Fixed-latency data-memory responder with stall and error.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dmem_responder_if.slave  bus
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam int                c_CW       = $clog2(LATENCY + 1);
    localparam logic [c_CW-1:0]   c_CNT_LOAD = c_CW'(LATENCY - 1);
    localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);
    localparam logic [WORD_W-1:0] c_DEPTH    = WORD_W'(DEPTH);

    dmem_state_t        r_state, w_next;
    logic [c_CW-1:0]    r_cnt, w_cnt_next;
    logic               r_rd, r_wr;
    logic [c_AW-1:0]    r_addr;
    logic [WORD_W-1:0]  r_wdata;
    dmem_cause_t        r_cause;

    logic               w_req, w_accept, w_go_resp, w_in_idle;
    logic               w_op_rd, w_op_wr, w_ok;
    logic [c_AW-1:0]    w_idx;
    logic [WORD_W-1:0]  w_data;
    dmem_cause_t        w_live_cause, w_cause;

    assign w_req        = bus.MemRead | bus.MemWrite;
    assign w_in_idle    = (r_state == IDLE);
    assign w_accept     = w_in_idle & w_req;
    assign w_live_cause = classify(bus.MemRead, bus.MemWrite, bus.Addr, c_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_go_resp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_cnt_next = c_CNT_LOAD;
                    if (LATENCY > 1) begin
                        w_next = WAIT;
                    end else begin
                        w_next    = RESP;
                        w_go_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - c_CNT_ONE;
                if (r_cnt <= c_CNT_ONE) begin
                    w_next    = RESP;
                    w_go_resp = 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cause <= NONE;
        end else if (w_accept) begin
            r_rd    <= bus.MemRead;
            r_wr    <= bus.MemWrite;
            r_addr  <= bus.Addr[c_AW+1:2];
            r_wdata <= bus.WriteData;
            r_cause <= w_live_cause;
        end
    end

    // With LATENCY=1 the edge into RESP is the acceptance edge itself, so the
    // request must come straight from the bus rather than from the latches.
    assign w_op_rd = w_in_idle ? bus.MemRead          : r_rd;
    assign w_op_wr = w_in_idle ? bus.MemWrite         : r_wr;
    assign w_idx   = w_in_idle ? bus.Addr[c_AW+1:2]   : r_addr;
    assign w_data  = w_in_idle ? bus.WriteData        : r_wdata;
    assign w_cause = w_in_idle ? w_live_cause         : r_cause;
    assign w_ok    = (w_cause == NONE);

    dmem_array #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (w_go_resp & w_ok & w_op_wr & ~rst),
        .re    (w_go_resp & w_ok & w_op_rd & ~rst),
        .clr   (w_go_resp & ~w_ok & ~rst),
        .waddr (w_idx),
        .wdata (w_data),
        .rdata (bus.ReadData)
    );

    assign bus.Ready = (r_state == RESP);
    assign bus.Error = (r_state == RESP) & (r_cause != NONE);
    assign bus.Stall = w_req & ~bus.Ready;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Random + directed bench for dmem_responder at LATENCY 2 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: LATENCY=2 instance, index 1: LATENCY=1 instance.
    logic        rs  [2];
    logic        mr  [2];
    logic        mw  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic        rdy [2];
    logic        stl [2];
    logic        err [2];
    logic [31:0] rdd [2];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    assign bus0.MemRead = mr[0];  assign bus0.MemWrite = mw[0];
    assign bus0.Addr    = ad[0];  assign bus0.WriteData = wd[0];
    assign bus1.MemRead = mr[1];  assign bus1.MemWrite = mw[1];
    assign bus1.Addr    = ad[1];  assign bus1.WriteData = wd[1];
    assign rdy[0] = bus0.Ready;   assign stl[0] = bus0.Stall;
    assign err[0] = bus0.Error;   assign rdd[0] = bus0.ReadData;
    assign rdy[1] = bus1.Ready;   assign stl[1] = bus1.Stall;
    assign err[1] = bus1.Error;   assign rdd[1] = bus1.ReadData;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut_l2 (
        .clk (clk), .rst (rs[0]), .bus (bus0)
    );
    dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut_l1 (
        .clk (clk), .rst (rs[1]), .bus (bus1)
    );

    // Reference model: plain word arrays plus a "value known" flag.
    logic [31:0] ref_mem   [2][256];
    bit          ref_known [2][256];

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One request starting at posedge+1 of an IDLE cycle; returns at posedge+1
    // of the cycle after Ready, leaving the request lines asserted.
    task automatic req(input int d, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data, input bit chg);
        int          lat;
        bit          e;
        int          idx;
        logic [31:0] exp_rd;
        lat = (d == 0) ? 2 : 1;
        e   = (addr[1:0] != 2'b00) || (addr >= 32'd1024) || (rd && wr);
        idx = int'(addr[9:2]);
        mr[d] = rd; mw[d] = wr; ad[d] = addr; wd[d] = data;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            check_eq("ready", 32'(rdy[d]), 32'(c == lat));
            check_eq("stall", 32'(stl[d]), 32'(c != lat));
            if (chg && c == 1 && c < lat) begin
                ad[d] = addr ^ 32'h4;
                wd[d] = ~data;
            end
            if (c == lat) begin
                check_eq("error", 32'(err[d]), 32'(e));
                if (e)
                    check_eq("rdata_err", rdd[d], 32'h0);
                else if (rd && ref_known[d][idx]) begin
                    exp_rd = ref_mem[d][idx];
                    check_eq("rdata", rdd[d], exp_rd);
                end
            end
        end
        if (!e && wr) begin
            ref_mem[d][idx]   = data;
            ref_known[d][idx] = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int d, input int n);
        mr[d] = 1'b0; mw[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_ready", 32'(rdy[d]), 32'h0);
            check_eq("idle_stall", 32'(stl[d]), 32'h0);
            @(posedge clk); #1;
        end
    endtask

    task automatic random_run(input int d, input int n);
        int          kind;
        bit          rd, wr;
        logic [31:0] addr;
        for (int i = 0; i < n; i++) begin
            kind = int'($urandom_range(0, 9));
            rd   = $urandom_range(0, 1) == 1;
            wr   = !rd;
            addr = {24'h0, 2'b00, 4'($urandom_range(0, 15)), 2'b00};
            if (kind == 0)
                addr = addr | 32'($urandom_range(1, 3));
            else if (kind == 1)
                addr = 32'h400 | {$urandom} << 2;
            else if (kind == 2)
                rd = 1'b1;
            wr = (kind == 2) ? 1'b1 : wr;
            req(d, rd, wr, addr, $urandom, d == 0 && $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0)
                idle(d, int'($urandom_range(1, 2)));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rs[d] = 1'b1; mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = '0; wd[d] = '0;
            for (int k = 0; k < 256; k++) ref_known[d][k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_ready", 32'(rdy[d]), 32'h0);
            check_eq("rst_error", 32'(err[d]), 32'h0);
            check_eq("rst_rdata", rdd[d], 32'h0);
            check_eq("rst_stall", 32'(stl[d]), 32'h0);
            rs[d] = 1'b0;
        end
        @(posedge clk); #1;

        // Store/load, misaligned store, out of range, conflict (LATENCY=2)
        req(0, 0, 1, 32'h10, 32'hDEADBEEF, 0);
        req(0, 1, 0, 32'h10, 32'h0, 0);
        req(0, 0, 1, 32'h13, 32'h12345678, 0);
        req(0, 1, 0, 32'h10, 32'h0, 0);
        req(0, 1, 0, 32'h400, 32'h0, 0);
        req(0, 1, 1, 32'h10, 32'h55555555, 0);
        req(0, 1, 0, 32'h10, 32'h0, 0);
        idle(0, 1);

        // Address/data change during WAIT must not affect the latched request
        req(0, 0, 1, 32'h34, 32'hA5A5A5A5, 0);
        req(0, 0, 1, 32'h30, 32'h600DF00D, 1);
        req(0, 1, 0, 32'h30, 32'h0, 0);
        req(0, 1, 0, 32'h34, 32'h0, 0);

        // Reset during WAIT aborts the store
        req(0, 0, 1, 32'h20, 32'h11111111, 0);
        mr[0] = 1'b0; mw[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'hCAFEF00D;
        @(negedge clk);
        check_eq("abort_c0_ready", 32'(rdy[0]), 32'h0);
        @(negedge clk);
        check_eq("abort_c1_ready", 32'(rdy[0]), 32'h0);
        rs[0] = 1'b1;
        #1;
        check_eq("abort_rst_ready", 32'(rdy[0]), 32'h0);
        check_eq("abort_rst_stall", 32'(stl[0]), 32'h1);
        @(negedge clk);
        check_eq("abort_ready", 32'(rdy[0]), 32'h0);
        check_eq("abort_error", 32'(err[0]), 32'h0);
        check_eq("abort_rdata", rdd[0], 32'h0);
        mw[0] = 1'b0;
        rs[0] = 1'b0;
        @(negedge clk);
        check_eq("abort_post_ready", 32'(rdy[0]), 32'h0);
        @(posedge clk); #1;
        req(0, 1, 0, 32'h20, 32'h0, 0);
        idle(0, 1);

        // Back-to-back stores held across three addresses (LATENCY=1)
        req(1, 0, 1, 32'h0, 32'h0BAD0000, 0);
        req(1, 0, 1, 32'h4, 32'h0BAD0004, 0);
        req(1, 0, 1, 32'h8, 32'h0BAD0008, 0);
        req(1, 1, 0, 32'h0, 32'h0, 0);
        req(1, 1, 0, 32'h4, 32'h0, 0);
        req(1, 1, 0, 32'h8, 32'h0, 0);
        req(1, 1, 0, 32'h401, 32'h0, 0);
        idle(1, 1);

        random_run(0, 60);
        idle(0, 1);
        random_run(1, 60);
        idle(1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the memory stage of the core. It consumes the `MemRead`/`MemWrite` control strobes that the control unit produces, along with the ALU-computed address and the store data. It services each request from an internal word array after a fixed, parameterised latency, and returns read data with a one-cycle `Ready` pulse. While a request is outstanding it holds `Stall` high so the pipeline freezes. Misaligned, out-of-range and conflicting requests complete with `Error` and leave memory unmodified.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: cycles from acceptance to `Ready`; ≥ 1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `MemRead`  in  1  load request strobe; held by core until `Ready`.
- `MemWrite`  in  1  store request strobe; held by core until `Ready`.
- `Addr`  in  32  byte address, word-aligned.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  load result; valid only while `Ready`=1.
- `Ready`  out  1  one-cycle completion pulse.
- `Stall`  out  1  `(MemRead|MemWrite) & ~Ready`, combinational.
- `Error`  out  1  qualifies `Ready`: the request was rejected.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - If `MemRead|MemWrite`, latch op, `Addr` and `WriteData`, and classify the request.
  - Load the counter with `LATENCY-1`.
  - Go to WAIT if `LATENCY>1`, else go to RESP.
- **WAIT:** decrement the counter. When it reaches 0, go to RESP.
- **Edge into RESP:**
  - Valid write: commits `mem[Addr[$clog2(DEPTH)+1:2]]`.
  - Valid read: captures that word into the `ReadData` register.
  - Error: `ReadData` register ← 0, no write.
- **RESP:** `Ready`=1 for exactly one cycle, then go to IDLE. A request still held in IDLE is accepted as a new request, so back-to-back throughput is one request per `LATENCY+1` cycles.
- **Error classes:**
  - `Addr[1:0]`≠0.
  - `Addr[31:2] ≥ DEPTH`.
  - `MemRead&MemWrite` both high.
- **Input changes:** inputs changing during WAIT are ignored because they were latched at acceptance.
- **Storage:** the memory array has no reset. Contents survive `rst`.

## Timing
- **Reset values:** state=IDLE, `Ready`=0, `Error`=0, `ReadData`=0, counter=0.
- **Latency:** a request accepted at edge k gives `Ready` high during cycle k+`LATENCY`.
- **Read-after-write:** a read immediately after a write to the same word returns the new data, because the write committed before the read was accepted.
- **Reset mid-request:** the request is aborted asynchronously with no write. The next edge after deassertion starts in IDLE, and a held request is re-accepted.
- **Stall:** is not registered. It drops in the same cycle as `Ready`.
- **No request:** no state change and no write.

## Structure
- **Package `dmem_pkg`:**
  - `dmem_state_t` enum (IDLE/WAIT/RESP).
  - `WORD_W`=32.
  - Error-cause enum: NONE/MISALIGN/RANGE/CONFLICT. Internal, kept for debug.
- **Sub-module `dmem_array`:** a single-port synchronous word RAM (`we`, `waddr`, `wdata`, registered `rdata`). It isolates the storage so it can later be replaced by a macro.
- **Counter width:** `$clog2(LATENCY+1)`.

## Test plan
1. **Store then load, `LATENCY`=2.** Store 0xDEADBEEF to 0x10, then load 0x10.
   - `Ready` at cycle 2 for each request.
   - Load returns 0xDEADBEEF with `Error`=0.
   - `Stall`=1 for cycles 0–1 of each request.
2. **Misaligned store.** Store 0x12345678 to 0x13.
   - `Ready`&`Error` at cycle 2.
   - A subsequent load of 0x10 still returns 0xDEADBEEF.
3. **Out of range and conflict, `DEPTH`=256.**
   - Load from 0x400: `Error`=1, `ReadData`=0.
   - `MemRead`=`MemWrite`=1: `Error`=1, no write.
4. **Back-to-back with `LATENCY`=1.** Hold `MemWrite` across three addresses 0x0/0x4/0x8.
   - `Ready` pulses every 2nd cycle.
   - Reads afterwards return the written values.
5. **Reset mid-request.** Assert `rst` during WAIT of a store of 0xCAFEF00D to 0x20.
   - `Ready` never pulses for that request.
   - A load of 0x20 after reset returns the prior contents, not 0xCAFEF00D.
6. **Input change during WAIT.** Change `Addr`/`WriteData` during WAIT.
   - The latched values are used: a read of the original address returns the original data.
